// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the index of the final quotient step.
package divider32_seq_pkg;
  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_EXEC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [4:0] DIV_LAST = 5'd31;
endpackage

// File: rtl/divider32_seq_cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups with the group
// carries chained between them.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [31:0] w_g, w_p, w_c;
  logic [8:0]  w_gc;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = ci;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    logic w_grp_g, w_grp_p;

    assign w_c[B]   = w_gc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                    | (w_p[B+1] & w_p[B] & w_gc[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                    | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);

    assign w_grp_g = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                   | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_grp_p = &w_p[B+3:B];
    assign w_gc[k+1] = w_grp_g | (w_grp_p & w_gc[k]);
  end

  assign s  = w_p ^ w_c;
  assign co = w_gc[8];
endmodule

// File: rtl/divider32_seq.sv
// Iterative 32-bit unsigned restoring divider: one quotient bit per cycle,
// trial subtraction through a single shared cla32.
module divider32_seq
  import divider32_seq_pkg::*;
#(
  parameter int DW = DIV_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_clear,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          busy,
  output logic          op_done,
  output logic          div_by_zero
);
  div_state_e    r_state;
  logic [4:0]    r_cnt;
  logic [DW-1:0] r_rem, r_quo, r_dvs;

  logic [DW:0]   w_s;
  logic [DW-1:0] w_diff, w_rem_nxt, w_quo_nxt;
  logic          w_co, w_take, w_accept, w_step, w_last;

  assign w_accept = op_start & ~op_clear & (r_state != DIV_EXEC);
  assign w_step   = (r_state == DIV_EXEC) & ~op_clear;
  assign w_last   = w_step & (r_cnt == DIV_LAST);

  // S[32] set means the shifted partial remainder already exceeds any divisor.
  assign w_s = {r_rem, r_quo[DW-1]};
  cla32 u_cla (
    .a  (w_s[DW-1:0]),
    .b  (~r_dvs),
    .ci (1'b1),
    .s  (w_diff),
    .co (w_co)
  );
  assign w_take    = w_s[DW] | w_co;
  assign w_rem_nxt = w_take ? w_diff : w_s[DW-1:0];
  assign w_quo_nxt = {r_quo[DW-2:0], w_take};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (op_clear) begin
      r_state     <= DIV_IDLE;
      r_cnt       <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE, DIV_DONE: if (op_start) begin
          r_cnt       <= '0;
          div_by_zero <= (divisor == '0);
          if (divisor == '0) begin
            r_state <= DIV_DONE;
            busy    <= 1'b0;
            op_done <= 1'b1;
          end else begin
            r_state <= DIV_EXEC;
            busy    <= 1'b1;
            op_done <= 1'b0;
          end
        end
        DIV_EXEC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == DIV_LAST) begin
            r_state <= DIV_DONE;
            busy    <= 1'b0;
            op_done <= 1'b1;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (w_accept) begin
      r_dvs <= divisor;
      r_rem <= '0;
      r_quo <= dividend;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (w_step) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        quotient  <= w_quo_nxt;
        remainder <= w_rem_nxt;
      end
    end
  end
endmodule

// File: tb/tb_divider32_seq.sv
// Scoreboard bench for divider32_seq: the driver pushes expected results from
// plain / and % arithmetic; a negedge monitor pops on every new completion.
module tb_divider32_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_start, op_clear;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        busy, op_done, div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          busy_cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = '0, last_r = '0;

  divider32_seq #(.DW(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .op_done     (op_done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.busy_cycles = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.busy_cycles = 32;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: a completion is op_done rising, or op_done staying high across
  // an accepted start (divide-by-zero issued back-to-back from DONE).
  logic prev_done = 1'b0, prev_acc = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_done = 1'b0; prev_acc = 1'b0; bcnt = 0;
    end else begin
      if (prev_acc) bcnt = 0;
      if (busy) bcnt++;
      if (op_done && (!prev_done || prev_acc)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got q=%h r=%h with empty scoreboard", quotient, remainder);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
          chk("busy_cycles", bcnt, e.busy_cycles);
        end
      end
      prev_done = op_done;
      prev_acc  = op_start && !op_clear && !busy;
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    @(posedge clk); #1;
    dividend = a; divisor = b; op_start = 1'b1;
    if (push) begin
      e = model(a, b);
      sb.push_back(e);
      last_q = e.q; last_r = e.r;
    end
    @(posedge clk); #1;
    op_start = 1'b0;
    dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!op_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got op_done=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [31:0] a, b;
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_remainder", remainder, 32'h0);
    chk("rst_flags", {29'b0, busy, op_done, div_by_zero}, 32'h0);
    reset_n = 1'b1;

    start_op(32'd100, 32'd7, 1'b1);
    chk("busy_after_accept", {31'b0, busy}, 32'h1);
    wait_done();
    run(32'hFFFF_FFFF, 32'h8000_0000);
    run(32'd5, 32'd10);
    run(32'hFFFF_FFFF, 32'd1);

    start_op(32'd1234, 32'd0, 1'b1);
    chk("dz_done_at_E0", {30'b0, op_done, div_by_zero}, 32'h3);
    run(32'd9, 32'd0);     // back-to-back divide-by-zero from DONE
    run(32'd77, 32'd3);

    // op_start during EXEC is ignored
    start_op(32'd100, 32'd7, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    op_start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(posedge clk); #1;
    op_start = 1'b0;
    wait_done();

    // op_clear mid-run aborts, previous results retained
    run(32'd5, 32'd10);
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0;
    chk("clear_flags", {30'b0, busy, op_done}, 32'h0);
    chk("clear_kept_q", quotient, last_q);
    chk("clear_kept_r", remainder, last_r);

    // clear wins over a simultaneous start from DONE
    run(32'd50, 32'd6);
    op_start = 1'b1; op_clear = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    op_start = 1'b0; op_clear = 1'b0;
    chk("clear_prio_flags", {30'b0, busy, op_done}, 32'h0);
    chk("clear_prio_q", quotient, last_q);

    // asynchronous reset mid-EXEC
    start_op(32'd100, 32'd7, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #3 reset_n = 1'b0;
    #1;
    chk("arst_quotient", quotient, 32'h0);
    chk("arst_remainder", remainder, 32'h0);
    chk("arst_flags", {29'b0, busy, op_done, div_by_zero}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run(32'd100, 32'd7);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run(a, b);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider32_seq.md
# divider32_seq

Iterative 32-bit unsigned restoring divider for the mini processor ALU, the inverse counterpart to the combinational multiply path. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per cycle, using a single shared `cla32` adder for the trial subtraction. It reports completion and divide-by-zero through a start/done handshake to the ALU controller.

## Interface
- `DW`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op_start`  in  1  start pulse; sampled only in IDLE or DONE.
- `op_clear`  in  1  synchronous abort/clear; has priority over `op_start`.
- `dividend`  in  32  numerator; captured on accepted `op_start`.
- `divisor`  in  32  denominator; captured on accepted `op_start`.
- `quotient`  out  32  registered result; updated only on completion.
- `remainder`  out  32  registered result; updated only on completion.
- `busy`  out  1  high while in EXEC.
- `op_done`  out  1  high while in DONE.
- `div_by_zero`  out  1  high in DONE when the captured divisor was 0.

## Operation
- States: IDLE, EXEC, DONE. Reset → IDLE. All outputs reset to 0.
- IDLE/DONE + `op_start` (with `op_clear`=0):
  - Capture the operands.
  - Set R=0, Q=dividend, cnt=0.
  - Clear `div_by_zero`.
  - Go to EXEC; if divisor==0, go to DONE instead.
- Divisor==0: `quotient`=32'hFFFFFFFF, `remainder`=dividend, `div_by_zero`=1.
- EXEC step, one per cycle:
  - S = {R, Q[31]}, 33 bits.
  - `cla32`(a=S[31:0], b=~divisor, ci=1) → s, co.
  - accept = S[32] | co.
  - R ← accept ? s : S[31:0].
  - Q ← {Q[30:0], accept}.
  - cnt ← cnt+1.
- When the step with cnt==31 completes: write Q/R into `quotient`/`remainder`, go to DONE.
- DONE: hold results and `op_done` until `op_clear` (→ IDLE, results kept) or `op_start` (new operation).
- `op_start` during EXEC: ignored.
- `op_clear` in any state: → IDLE next cycle, cnt=0. An aborted operation leaves `quotient`/`remainder` unchanged.
- `op_start` and `op_clear` asserted together: clear wins.
- Operands may change freely after the accept cycle; internal copies are used.

## Timing
- Accept edge E0: `busy`=1 from E0.
- Steps run at E1..E32.
- E32: `op_done`=1 and results valid; `busy`=0. Latency is 32 cycles from accept to done.
- Divide-by-zero: `op_done`/`div_by_zero`=1 at E0 itself, with no EXEC cycles.
- Back-to-back: `op_start` in the same cycle `op_done` is high is accepted. `op_done` falls at that edge.
- Reset mid-operation: asynchronous return to IDLE; all outputs are 0 immediately.

## Structure
- Shared include file contents:
  - state encodings `DIV_IDLE`=2'b00, `DIV_EXEC`=2'b01, `DIV_DONE`=2'b10.
  - `DIV_LAST`=5'd31.
- Sub-module: the existing `cla32` is instantiated once for the trial subtract.
  - No other adder is used.
  - The counter increment uses a plain 5-bit register +1.
- Coding split: FSM and counter in one always block; datapath registers in another.

## Test plan
- 100 / 7 → after 32 cycles: `quotient`=14, `remainder`=2, `div_by_zero`=0, `busy` high for exactly 32 cycles.
- 32'hFFFFFFFF / 32'h80000000 → `quotient`=1, `remainder`=32'h7FFFFFFF. This exercises the S[32] accept path.
- 5 / 10 → `quotient`=0, `remainder`=5. 32'hFFFFFFFF / 1 → `quotient`=32'hFFFFFFFF, `remainder`=0.
- 1234 / 0 → `op_done`=1 and `div_by_zero`=1 one edge after accept; `quotient`=32'hFFFFFFFF, `remainder`=1234.
- `op_start` pulsed at step 10 of a run: ignored, run finishes normally. `op_clear` at step 10 of a 100/7 run: IDLE next cycle, previous results retained.
- `reset_n` low mid-EXEC → all outputs 0 asynchronously. A new 100/7 afterward completes correctly. Random 1000-pair compare against the `/` and `%` operators.
